// File: rtl/aes_pkg.sv
// Shared AES constants, controller state encoding and the GF(2^8) helpers
// used by the inverse-round datapath.
package aes_pkg;

  localparam int AES_BLK_W = 128;
  localparam int NR_AES128 = 10;
  localparam int NR_AES192 = 12;
  localparam int NR_AES256 = 14;

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} aes_state_e;

  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = gf_xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = a;
    for (int i = 0; i < 7; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] t;
    t = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    return gf_inv(t);
  endfunction

  // Byte k of a block sits at bits [127-8k -: 8]; row = k%4, column = k/4.
  function automatic logic [AES_BLK_W-1:0] inv_shift_rows(input logic [AES_BLK_W-1:0] s);
    logic [AES_BLK_W-1:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [AES_BLK_W-1:0] inv_sub_bytes(input logic [AES_BLK_W-1:0] s);
    logic [AES_BLK_W-1:0] o;
    o = '0;
    for (int k = 0; k < 16; k++) begin
      o[127-8*k -: 8] = inv_sbox(s[127-8*k -: 8]);
    end
    return o;
  endfunction

  function automatic logic [AES_BLK_W-1:0] inv_mix_columns(input logic [AES_BLK_W-1:0] s);
    logic [AES_BLK_W-1:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round; last_i drops InvMixColumns for the
// final round.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [AES_BLK_W-1:0] istate_i,
  input  logic [AES_BLK_W-1:0] rk_i,
  input  logic                 last_i,
  output logic [AES_BLK_W-1:0] ostate_o
);

  logic [AES_BLK_W-1:0] sub_w;
  logic [AES_BLK_W-1:0] ark_w;

  always_comb begin
    sub_w    = inv_sub_bytes(inv_shift_rows(istate_i));
    ark_w    = sub_w ^ rk_i;
    ostate_o = last_i ? ark_w : inv_mix_columns(ark_w);
  end

endmodule

// File: rtl/aes_inv_round_ctrl.sv
// Iterative AES inverse-cipher sequencer: one inverse round per clock over a
// single state register, round keys fetched by index from an external store.
module aes_inv_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR     = NR_AES128,
  parameter int KIDX_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AES_BLK_W-1:0] in_data,
  output logic [KIDX_W-1:0]    rk_idx,
  input  logic [AES_BLK_W-1:0] rk_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AES_BLK_W-1:0] out_data,
  output logic                 busy
);

  aes_state_e           fsm_q, fsm_d;
  logic [KIDX_W-1:0]    cnt_q, cnt_d;
  logic [AES_BLK_W-1:0] blk_q, blk_d;
  logic [AES_BLK_W-1:0] rnd_w;
  logic                 last_w;

  aes_inv_round u_round (
    .istate_i (blk_q),
    .rk_i     (rk_data),
    .last_i   (last_w),
    .ostate_o (rnd_w)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q <= IDLE;
      cnt_q <= '0;
      blk_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      cnt_q <= cnt_d;
      blk_q <= blk_d;
    end
  end

  // rk_idx depends only on fsm_q/cnt_q so the key store sees a stable index.
  always_comb begin
    fsm_d     = fsm_q;
    cnt_d     = cnt_q;
    blk_d     = blk_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    last_w    = 1'b0;
    rk_idx    = KIDX_W'(NR);
    case (fsm_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          blk_d = in_data ^ rk_data;
          cnt_d = KIDX_W'(NR - 1);
          fsm_d = ROUND;
        end
      end
      ROUND: begin
        busy   = 1'b1;
        rk_idx = cnt_q;
        blk_d  = rnd_w;
        cnt_d  = cnt_q - KIDX_W'(1);
        if (cnt_q == KIDX_W'(1)) fsm_d = FINAL;
      end
      FINAL: begin
        busy   = 1'b1;
        rk_idx = '0;
        last_w = 1'b1;
        blk_d  = rnd_w;
        fsm_d  = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  assign out_data = blk_q;

endmodule
